// File: rtl/uart_rx_fifo.sv
// UART receiver: 2-flop sync, 3-sample majority vote, parity/stop/break checks, FWFT byte FIFO.
// Latency: good byte visible on o_RX_Valid the cycle after the mid+1 stop-bit decision.
// Backpressure: i_RX_Ready pops the head; a good byte arriving at a full FIFO is dropped with o_Overrun.
module uart_rx_fifo #(
  parameter int CLKS_PER_BIT = 217,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                          i_Clock,
  input  logic                          i_Rst_n,
  input  logic                          i_RX_Serial,
  output logic                          o_RX_Valid,
  output logic [7:0]                    o_RX_Byte,
  input  logic                          i_RX_Ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_FIFO_Count,
  output logic                          o_Parity_Err,
  output logic                          o_Frame_Err,
  output logic                          o_Break,
  output logic                          o_Overrun,
  output logic                          o_RX_Busy
);

  localparam int         MID     = (CLKS_PER_BIT - 1) / 2;
  localparam logic [7:0] C_LAST  = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] C_S0    = 8'(MID - 1);
  localparam logic [7:0] C_S1    = 8'(MID);
  localparam logic [7:0] C_S2    = 8'(MID + 1);
  localparam logic       PEN     = (PARITY_EN != 0);
  localparam logic       ODD_BIT = (PARITY_ODD != 0);
  localparam int         AW      = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK_WAIT} state_t;

  state_t      state;
  logic        rx_meta, rx_sync, rx_prev, armed;
  logic [1:0]  sync_fill;
  logic [7:0]  bit_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  rx_byte;
  logic        par_bit, samp_a, samp_b;
  logic        vote, last, decide, par_bad, is_break;
  logic        push_vld;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic        full, pop_fire, wr_fire;

  assign vote     = (samp_a & samp_b) | (samp_a & rx_sync) | (samp_b & rx_sync);
  assign last     = (bit_cnt == C_LAST);
  assign decide   = (bit_cnt == C_S2);
  assign par_bad  = PEN && (par_bit != ((^rx_byte) ^ ODD_BIT));
  assign is_break = (rx_byte == 8'd0) && (!PEN || !par_bit);
  assign push_vld = (state == STOP) && decide && vote && !par_bad;
  assign o_RX_Busy = (state != IDLE);

  // Synchronizer, edge history and arming. sync_fill keeps the reset-value 1s in the
  // sync chain from arming the receiver before a real pad sample has reached rx_sync.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      rx_meta   <= 1'b1;
      rx_sync   <= 1'b1;
      rx_prev   <= 1'b1;
      sync_fill <= 2'd0;
      armed     <= 1'b0;
    end else begin
      rx_meta <= i_RX_Serial;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
      if (sync_fill != 2'd2) sync_fill <= sync_fill + 2'd1;
      if (sync_fill == 2'd2 && rx_sync) armed <= 1'b1;
    end
  end

  // Frame state machine with bit timing, vote sampling and registered error pulses.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state        <= IDLE;
      bit_cnt      <= 8'd0;
      bit_idx      <= 3'd0;
      rx_byte      <= 8'd0;
      par_bit      <= 1'b0;
      samp_a       <= 1'b0;
      samp_b       <= 1'b0;
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Break      <= 1'b0;
    end else begin
      o_Parity_Err <= 1'b0;
      o_Frame_Err  <= 1'b0;
      o_Break      <= 1'b0;
      if (bit_cnt == C_S0) samp_a <= rx_sync;
      if (bit_cnt == C_S1) samp_b <= rx_sync;
      bit_cnt <= last ? 8'd0 : bit_cnt + 8'd1;
      case (state)
        IDLE: begin
          bit_cnt <= 8'd0;
          if (armed && rx_prev && !rx_sync) state <= START;
        end
        START: begin
          if (decide && vote) begin
            state   <= IDLE;
            bit_cnt <= 8'd0;
          end else if (last) begin
            state   <= DATA;
            bit_idx <= 3'd0;
          end
        end
        DATA: begin
          if (decide) rx_byte[bit_idx] <= vote;
          if (last) begin
            if (bit_idx == 3'd7) state <= PEN ? PARITY : STOP;
            else bit_idx <= bit_idx + 3'd1;
          end
        end
        PARITY: begin
          if (decide) par_bit <= vote;
          if (last) state <= STOP;
        end
        STOP: begin
          if (decide) begin
            bit_cnt <= 8'd0;
            state   <= IDLE;
            if (!vote) begin
              o_Frame_Err <= 1'b1;
              if (is_break) begin
                o_Break <= 1'b1;
                state   <= BREAK_WAIT;
              end
            end else if (par_bad) begin
              o_Parity_Err <= 1'b1;
            end
          end
        end
        BREAK_WAIT: begin
          bit_cnt <= 8'd0;
          if (rx_sync) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pop_fire     = o_RX_Valid && i_RX_Ready;
  assign full         = (count == (AW+1)'(FIFO_DEPTH));
  assign wr_fire      = push_vld && (!full || pop_fire);
  assign o_RX_Valid   = (count != '0);
  assign o_RX_Byte    = mem[rd_ptr];
  assign o_FIFO_Count = count;

  // First-word-fall-through FIFO storage, pointers, occupancy and overrun pulse.
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      o_Overrun <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= 8'd0;
    end else begin
      o_Overrun <= push_vld && full && !pop_fire;
      if (wr_fire) begin
        mem[wr_ptr] <= rx_byte;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop_fire) rd_ptr <= rd_ptr + 1'b1;
      if (wr_fire && !pop_fire) count <= count + 1'b1;
      else if (!wr_fire && pop_fire) count <= count - 1'b1;
    end
  end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Bench for uart_rx_fifo: instance 0 is 8N1, instance 1 is 8E1, both 16 clocks per bit.
// Frames are driven bit-serially; a byte queue and pulse counters are the reference.
// Consumers are held, released or randomised per test through rdy.
module tb_uart_rx_fifo;

  localparam int CPB = 16;

  logic       clk;
  logic       rst_n;
  logic       rx   [2];
  logic       rdy  [2];
  logic       vld  [2];
  logic [7:0] dat  [2];
  logic [3:0] cnt  [2];
  logic       pe   [2];
  logic       fe   [2];
  logic       brk  [2];
  logic       ovr  [2];
  logic       busy [2];

  int n_checks = 0;
  int n_errors = 0;
  int n_pe [2] = '{0, 0};
  int n_fe [2] = '{0, 0};
  int n_brk[2] = '{0, 0};
  int n_ovr[2] = '{0, 0};
  logic [7:0] q0[$];
  logic [7:0] q1[$];
  bit rnd_rdy = 0;

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .FIFO_DEPTH(8)) u_dut0 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_RX_Serial(rx[0]),
    .o_RX_Valid(vld[0]), .o_RX_Byte(dat[0]), .i_RX_Ready(rdy[0]), .o_FIFO_Count(cnt[0]),
    .o_Parity_Err(pe[0]), .o_Frame_Err(fe[0]), .o_Break(brk[0]), .o_Overrun(ovr[0]),
    .o_RX_Busy(busy[0]));

  uart_rx_fifo #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .FIFO_DEPTH(8)) u_dut1 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_RX_Serial(rx[1]),
    .o_RX_Valid(vld[1]), .o_RX_Byte(dat[1]), .i_RX_Ready(rdy[1]), .o_FIFO_Count(cnt[1]),
    .o_Parity_Err(pe[1]), .o_Frame_Err(fe[1]), .o_Break(brk[1]), .o_Overrun(ovr[1]),
    .o_RX_Busy(busy[1]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  // Pulse counting and head-of-queue comparison on every accepted pop.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (pe[i])  n_pe[i]++;
      if (fe[i])  n_fe[i]++;
      if (brk[i]) n_brk[i]++;
      if (ovr[i]) n_ovr[i]++;
      if (vld[i] && rdy[i]) begin
        if (i == 0) begin
          check("pop0_expected", 32'(q0.size() != 0), 32'd1);
          if (q0.size() != 0) check("pop0_byte", 32'(dat[0]), 32'(q0.pop_front()));
        end else begin
          check("pop1_expected", 32'(q1.size() != 0), 32'd1);
          if (q1.size() != 0) check("pop1_byte", 32'(dat[1]), 32'(q1.pop_front()));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_rdy) begin
      rdy[0] = 1'($urandom_range(0, 1));
      rdy[1] = 1'($urandom_range(0, 1));
    end
  endtask

  function automatic logic [31:0] flags(input int i, input int b_pe, input int b_fe,
                                        input int b_brk, input int b_ovr);
    return {8'(n_pe[i] - b_pe), 8'(n_fe[i] - b_fe), 8'(n_brk[i] - b_brk), 8'(n_ovr[i] - b_ovr)};
  endfunction

  // Drive one frame and check the pulse totals it should produce. Instance 1 carries parity.
  task automatic frame(input int inst, input logic [7:0] d, input logic pbit, input logic stopb,
                       input bit full, input int glitch);
    logic [10:0] bits;
    int nb, b_pe, b_fe, b_brk, b_ovr;
    logic e_pe, e_fe, e_brk, e_ovr, pen, v;
    pen   = (inst == 1);
    bits  = '1;
    bits[0] = 1'b0;
    bits[8:1] = d;
    if (pen) begin bits[9] = pbit; bits[10] = stopb; nb = 11; end
    else     begin bits[9] = stopb; nb = 10; end
    e_pe = 0; e_fe = 0; e_brk = 0; e_ovr = 0;
    if (!stopb) begin
      e_fe  = 1;
      e_brk = (d == 8'd0) && (!pen || !pbit);
    end else if (pen && (pbit != ^d)) begin
      e_pe = 1;
    end else if (full) begin
      e_ovr = 1;
    end else if (inst == 0) q0.push_back(d);
    else q1.push_back(d);
    b_pe = n_pe[inst]; b_fe = n_fe[inst]; b_brk = n_brk[inst]; b_ovr = n_ovr[inst];
    for (int j = 0; j < nb * CPB; j++) begin
      v = bits[j / CPB];
      if (j == glitch) v = ~v;
      rx[inst] = v;
      tick();
    end
    rx[inst] = 1'b1;
    repeat (2 * CPB) tick();
    check($sformatf("flags%0d_%02h", inst, d), flags(inst, b_pe, b_fe, b_brk, b_ovr),
          {8'(e_pe), 8'(e_fe), 8'(e_brk), 8'(e_ovr)});
  endtask

  initial begin
    int b_pe, b_fe, b_brk, b_ovr;
    rst_n = 1'b0;
    rx[0] = 1'b1; rx[1] = 1'b1;
    rdy[0] = 1'b1; rdy[1] = 1'b1;
    repeat (3) tick();
    for (int i = 0; i < 2; i++)
      check($sformatf("reset_out%0d", i),
            {16'd0, 4'(cnt[i]), dat[i], vld[i], pe[i], fe[i], brk[i]}, 32'd0);
    check("reset_busy_ovr", {30'd0, busy[0] | busy[1], ovr[0] | ovr[1]}, 32'd0);
    rst_n = 1'b1;
    repeat (6) tick();

    // Basic 8N1 byte and parity error / recovery
    frame(0, 8'hA5, 1'b0, 1'b1, 0, -1);
    check("a5_count", 32'(cnt[0]), 32'd0);
    frame(1, 8'h3C, 1'b1, 1'b1, 0, -1);
    check("par_count", 32'(cnt[1]), 32'd0);
    frame(1, 8'h3C, 1'b0, 1'b1, 0, -1);

    // Fill to depth with the consumer stalled, ninth byte overruns
    rdy[0] = 1'b0;
    for (int k = 1; k <= 9; k++) frame(0, 8'(k), 1'b0, 1'b1, (k == 9), -1);
    check("full_count", 32'(cnt[0]), 32'd8);
    check("full_head", {23'd0, vld[0], dat[0]}, {23'd0, 1'b1, 8'h01});
    rdy[0] = 1'b1;
    repeat (20) tick();
    check("drain_empty", {27'd0, vld[0], cnt[0]}, 32'd0);
    check("drain_model", 32'(q0.size()), 32'd0);

    // Frame error, then a long break
    frame(0, 8'h55, 1'b0, 1'b0, 0, -1);
    b_pe = n_pe[0]; b_fe = n_fe[0]; b_brk = n_brk[0]; b_ovr = n_ovr[0];
    rx[0] = 1'b0;
    repeat (20 * CPB) tick();
    check("break_busy", 32'(busy[0]), 32'd1);
    rx[0] = 1'b1;
    repeat (6) tick();
    check("break_idle", 32'(busy[0]), 32'd0);
    check("break_flags", flags(0, b_pe, b_fe, b_brk, b_ovr), 32'h00010100);
    repeat (CPB) tick();
    frame(0, 8'h7E, 1'b0, 1'b1, 0, -1);

    // False start from a short idle glitch; mid-bit glitch absorbed by the vote
    b_pe = n_pe[0]; b_fe = n_fe[0]; b_brk = n_brk[0]; b_ovr = n_ovr[0];
    rx[0] = 1'b0;
    repeat (3) tick();
    rx[0] = 1'b1;
    repeat (3 * CPB) tick();
    check("glitch_flags", flags(0, b_pe, b_fe, b_brk, b_ovr), 32'd0);
    check("glitch_state", {27'd0, busy[0], cnt[0]}, 32'd0);
    frame(0, 8'h00, 1'b0, 1'b1, 0, 4 * CPB + (CPB - 1) / 2 + 1);

    // Reset in the middle of bit 4, released with the line still low
    b_pe = n_pe[0]; b_fe = n_fe[0]; b_brk = n_brk[0]; b_ovr = n_ovr[0];
    rx[0] = 1'b0;
    repeat (5 * CPB + 8) tick();
    rst_n = 1'b0;
    repeat (2) tick();
    check("rst_mid_out", {22'd0, busy[0], vld[0], cnt[0], dat[0]}, 32'd0);
    rst_n = 1'b1;
    repeat (2 * CPB) tick();
    check("rst_low_state", {22'd0, busy[0], vld[0], cnt[0], dat[0]}, 32'd0);
    check("rst_low_flags", flags(0, b_pe, b_fe, b_brk, b_ovr), 32'd0);
    rx[0] = 1'b1;
    repeat (2 * CPB) tick();
    frame(0, 8'hC3, 1'b0, 1'b1, 0, -1);

    // Randomised frames on both instances with a randomly stalling consumer
    rnd_rdy = 1;
    for (int n = 0; n < 24; n++) begin
      int inst;
      logic [7:0] d;
      logic pb, sb;
      inst = int'($urandom_range(0, 1));
      d    = 8'($urandom);
      if ($urandom_range(0, 7) == 0) d = 8'h00;
      pb   = (^d) ^ ($urandom_range(0, 3) == 0);
      sb   = ($urandom_range(0, 5) != 0);
      frame(inst, d, pb, sb, 0, -1);
      if (!sb && d == 8'h00) repeat (CPB) tick();
    end
    rnd_rdy = 0;
    rdy[0] = 1'b1; rdy[1] = 1'b1;
    repeat (20) tick();
    check("rand_drain_model", 32'(q0.size() + q1.size()), 32'd0);
    check("rand_drain_dut", {24'd0, cnt[1], cnt[0]}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Robust UART receiver front-end with a buffered byte interface. It samples an asynchronous serial line through a synchronizer and decides each bit by majority vote. It checks optional parity, the stop bit, and line break, then queues good bytes in a first-word-fall-through FIFO with a valid/ready read port. It sits between the pad-side serial input and the byte consumers, replacing the bare receiver where loss-free buffering and error reporting are required.

## Interface
- CLKS_PER_BIT, 217: clocks per bit period (i_Clock freq / baud); must be ≥ 4 and ≤ 255.
- PARITY_EN, 0: 1 = a parity bit follows data bit 7.
- PARITY_ODD, 0: 1 = odd parity, 0 = even parity (ignored when PARITY_EN=0).
- FIFO_DEPTH, 8: receive FIFO entries; power of 2, ≥ 2.

Ports:
- i_Clock  input  1  sole clock.
- i_Rst_n  input  1  asynchronous, active-low reset.
- i_RX_Serial  input  1  asynchronous serial line; idle high, LSB first, 1 start bit, 8 data bits, optional parity, 1 stop bit.
- o_RX_Valid  output  1  FIFO non-empty; o_RX_Byte is valid.
- o_RX_Byte  output  8  FIFO head byte.
- i_RX_Ready  input  1  consumer pops the head when o_RX_Valid && i_RX_Ready.
- o_FIFO_Count  output  $clog2(FIFO_DEPTH)+1  current number of entries.
- o_Parity_Err  output  1  one-cycle pulse; parity mismatch, byte dropped.
- o_Frame_Err  output  1  one-cycle pulse; stop bit sampled 0, byte dropped.
- o_Break  output  1  one-cycle pulse; break detected (accompanies o_Frame_Err).
- o_Overrun  output  1  one-cycle pulse; good byte dropped because the FIFO was full.
- o_RX_Busy  output  1  state machine is not in IDLE.

## Operation
- Synchronizer: 2 flops, reset to 1. Edge detection uses a third registered copy of the line (prev). All decisions use the synchronized line.
- armed flag, reset 0: set on the first cycle the synchronized line is 1. Start detection requires armed.
- mid = (CLKS_PER_BIT-1)/2, integer division. Within each bit, the counter runs 0..CLKS_PER_BIT-1. The line is sampled at counts mid-1, mid and mid+1. The bit value is the majority of the three samples, decided at count mid+1.
- States:
  - IDLE: on armed && prev=1 && line=0, go to START with counter 0.
  - START: if the vote is 1, it is a false start; return to IDLE at count mid+1. Otherwise, at count CLKS_PER_BIT-1 go to DATA with bit index 0.
  - DATA: store the vote in byte[index]. At count CLKS_PER_BIT-1, increment index. After index 7, go to PARITY if PARITY_EN, else to STOP.
  - PARITY: store the vote as the received parity bit. At count CLKS_PER_BIT-1, go to STOP.
  - STOP: at count mid+1, evaluate:
    - vote 0 and all data bits 0 and (no parity or parity bit 0): pulse o_Break and o_Frame_Err; go to BREAK_WAIT.
    - vote 0 otherwise: pulse o_Frame_Err; go to IDLE.
    - vote 1 with parity mismatch: pulse o_Parity_Err; go to IDLE.
    - vote 1, good: push the byte; go to IDLE. This early return allows resync on back-to-back frames.
  - BREAK_WAIT: go to IDLE once the synchronized line is 1.
- Expected parity bit = ^byte XOR PARITY_ODD. Parity is checked only when PARITY_EN=1.
- FIFO:
  - Read and write pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
  - A separate count holds 0..FIFO_DEPTH.
  - o_RX_Byte = mem[rd_ptr]; no write-to-read bypass.
  - Push while full: the byte is dropped, o_Overrun pulses, contents are unchanged.
  - Push and pop in the same cycle while full: both take effect, no overrun, count unchanged.
  - Push and pop in the same cycle while not empty: both take effect, count unchanged.
  - Pop while empty is ignored.
- Only one error pulse fires per frame, except o_Break + o_Frame_Err, which fire together.

## Timing
- Reset values: all outputs 0, o_RX_Byte 0, FIFO empty, state IDLE, armed 0.
- Reset asserted mid-frame: the frame is aborted immediately and the partial byte discarded. After release, no start is detected until the line has been seen high.
- Line latency: 2 cycles from i_RX_Serial to the synchronized line.
- Start: the START state is entered on the cycle after the synchronized falling edge is seen.
- Error pulses and the FIFO write are registered on the cycle after the count mid+1 decision in STOP. o_RX_Valid and o_FIFO_Count update on that same cycle.
- Pop: o_RX_Byte shows the next entry and o_FIFO_Count decrements on the cycle after the valid && ready handshake.
- o_RX_Busy is high from the START entry cycle through the cycle that leaves STOP or BREAK_WAIT.

## Test plan
- CLKS_PER_BIT=16, 8N1, ready=1; send 0xA5 → one o_RX_Valid cycle with o_RX_Byte=0xA5; count returns 0; no error pulses.
- PARITY_EN=1, even; send 0x3C with parity bit 1 → single o_Parity_Err pulse; FIFO stays empty. Resend with parity 0 → 0x3C delivered.
- ready=0, FIFO_DEPTH=8; send 0x01..0x09 → count=8 and one o_Overrun pulse on the 9th byte. Raise ready → bytes 0x01..0x08 in order, then o_RX_Valid=0.
- Send 0x55 with stop bit 0 → o_Frame_Err only. Hold the line low for 20 bit times → o_Break and o_Frame_Err once, busy until the line rises. Then 0x7E is received correctly.
- 3-cycle low glitch in idle → false start; no byte and no error. A 1-cycle inverted glitch at count mid of bit 3 of 0x00 → 0x00 is still received (majority vote).
- Assert i_Rst_n low during bit 4, release with the line held low for 2 bit times → all outputs 0 and no byte. After the line goes high, the next frame 0xC3 is received correctly.
